// File: rtl/bram_line_packer.sv
// Packs host elements into BURST_LEN-wide BRAM lines across two ping-pong banks.
// Latency: a line is written one edge after the handshake (or flush) that completes it.
// Backpressure: in_ready drops while the bank being written is FULL; bank_release reopens it.
module bram_line_packer #(
  parameter int ELEM_W    = 16,
  parameter int IN_W      = 32,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 10,
  parameter int MSB_FIRST = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [IN_W-1:0]             in_data,
  output logic                        in_ready,
  input  logic [ADDR_W-1:0]           line_target,
  input  logic                        flush,
  input  logic [1:0]                  bank_release,
  output logic                        ram_wr_en,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [ELEM_W*BURST_LEN-1:0] ram_data,
  output logic [1:0]                  bank_full,
  output logic [ADDR_W-1:0]           bank_lines_0,
  output logic [ADDR_W-1:0]           bank_lines_1,
  output logic                        protocol_err
);

  localparam int LINE_W = ELEM_W * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] BANK_LINES = {1'b1, {(ADDR_W-1){1'b0}}};

  typedef enum logic [1:0] {FREE = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_st_t;

  bank_st_t             st_q [2];
  bank_st_t             st_d [2];
  logic                 wr_bank;
  logic [CNT_W-1:0]     elem_cnt;
  logic [ADDR_W-1:0]    line_idx;
  logic [ADDR_W-1:0]    tgt_q;
  logic [LINE_W-1:0]    line_q;

  logic                 accept;
  logic                 flush_ok;
  logic                 opening;
  logic                 line_done;
  logic                 emit;
  logic                 close;
  logic                 err_set;
  logic [CNT_W-1:0]     slot;
  logic [LINE_W-1:0]    line_next;
  logic [ADDR_W-1:0]    lines_after;
  logic [ADDR_W-1:0]    tgt_raw;
  logic [ADDR_W-1:0]    tgt_eff;
  logic [1:0]           rel_ok;
  logic [1:0]           rel_err;

  // Upper input bits carry no element data.
  generate
    if (IN_W > ELEM_W) begin : g_unused_hi
      logic unused_in_hi;
      assign unused_in_hi = ^in_data[IN_W-1:ELEM_W];
    end
  endgenerate

  // Output decode: accept only while the write bank is not owned by the consumer.
  always_comb begin
    in_ready = (st_q[wr_bank] != FULL);
  end

  // Line assembly, line-completion, bank-close and error detection.
  always_comb begin
    accept    = in_valid && in_ready;
    flush_ok  = flush && in_ready;
    opening   = accept && (st_q[wr_bank] == FREE);
    slot      = (MSB_FIRST != 0) ? (CNT_W'(BURST_LEN - 1) - elem_cnt) : elem_cnt;
    line_next = line_q;
    if (accept) begin
      line_next[int'(slot)*ELEM_W +: ELEM_W] = in_data[ELEM_W-1:0];
    end
    line_done   = accept && (elem_cnt == CNT_W'(BURST_LEN - 1));
    // A flush pads out any partial line; line_q is kept zeroed past the last element.
    emit        = line_done || (flush_ok && (accept || (elem_cnt != '0)));
    lines_after = line_idx + {{(ADDR_W-1){1'b0}}, emit};
    tgt_raw     = (line_target == '0) ? BANK_LINES : line_target;
    tgt_eff     = opening ? tgt_raw : tgt_q;
    close       = (emit && (lines_after == tgt_eff)) || (flush_ok && (lines_after != '0));
    for (int b = 0; b < 2; b++) begin
      rel_ok[b]  = bank_release[b] && (st_q[b] == FULL);
      rel_err[b] = bank_release[b] && (st_q[b] != FULL);
    end
    err_set = (|rel_err) || (flush && !in_ready);
  end

  // Bank ownership next state; open/close only touch the write bank, which is never FULL then.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (rel_ok[b]) begin
        st_d[b] = FREE;
      end
      if (1'(b) == wr_bank) begin
        if (opening) begin
          st_d[b] = FILLING;
        end
        if (close) begin
          st_d[b] = FULL;
        end
      end
    end
  end

  // Bank state register, with bank_full registered from the same next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]   <= FREE;
      st_q[1]   <= FREE;
      bank_full <= 2'b00;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      bank_full <= {st_d[1] == FULL, st_d[0] == FULL};
    end
  end

  // Datapath: element counter, line register, write port, bank pointer and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank      <= 1'b0;
      elem_cnt     <= '0;
      line_idx     <= '0;
      tgt_q        <= '0;
      line_q       <= '0;
      ram_wr_en    <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      bank_lines_0 <= '0;
      bank_lines_1 <= '0;
      protocol_err <= 1'b0;
    end else begin
      ram_wr_en <= emit;
      if (emit) begin
        ram_addr <= {wr_bank, line_idx[ADDR_W-2:0]};
        ram_data <= line_next;
      end
      if (emit) begin
        elem_cnt <= '0;
      end else if (accept) begin
        elem_cnt <= elem_cnt + CNT_W'(1);
      end
      line_q   <= emit ? '0 : line_next;
      line_idx <= close ? '0 : lines_after;
      if (opening) begin
        tgt_q <= tgt_raw;
      end
      if (close) begin
        wr_bank <= ~wr_bank;
        if (wr_bank) begin
          bank_lines_1 <= lines_after;
        end else begin
          bank_lines_0 <= lines_after;
        end
      end
      if (err_set) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_line_packer.sv
// Directed bench for bram_line_packer: line packing, ping-pong stalls, flush, release errors, reset.
// Latency: expects each line write one edge after its completing handshake or flush.
// Backpressure: drives elements only where in_ready is expected high and counts any miss.
module tb_bram_line_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready;
  logic [3:0]   line_target = 4'd2;
  logic         flush = 1'b0;
  logic [1:0]   bank_release = 2'b00;
  logic         ram_wr_en;
  logic [3:0]   ram_addr;
  logic [127:0] ram_data;
  logic [1:0]   bank_full;
  logic [3:0]   bank_lines_0;
  logic [3:0]   bank_lines_1;
  logic         protocol_err;

  int n_checks = 0;
  int n_fail = 0;
  int ready_miss = 0;

  logic [3:0]   wq_addr [$];
  logic [127:0] wq_data [$];

  always #5 clk = ~clk;

  bram_line_packer #(
    .ELEM_W(16), .IN_W(32), .BURST_LEN(8), .ADDR_W(4), .MSB_FIRST(0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .line_target(line_target), .flush(flush), .bank_release(bank_release),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_data(ram_data),
    .bank_full(bank_full), .bank_lines_0(bank_lines_0), .bank_lines_1(bank_lines_1),
    .protocol_err(protocol_err)
  );

  // Record every write strobe shortly after the edge that produced it.
  always @(posedge clk) begin
    #2;
    if (ram_wr_en === 1'b1) begin
      wq_addr.push_back(ram_addr);
      wq_data.push_back(ram_data);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] e);
    in_valid = 1'b1;
    in_data  = {16'hdead, e};
    if (in_ready !== 1'b1) ready_miss++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid     = 1'b0;
    flush        = 1'b0;
    bank_release = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_write(input string tag, input logic [3:0] a, input logic [127:0] d);
    if (wq_addr.size() == 0) begin
      check({tag, " present"}, 128'd0, 128'd1);
    end else begin
      check({tag, " addr"}, 128'(wq_addr.pop_front()), 128'(a));
      check({tag, " data"}, wq_data.pop_front(), d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values while rst is held.
    #3;
    check("rst wr_en", 128'(ram_wr_en), 128'd0);
    check("rst addr", 128'(ram_addr), 128'd0);
    check("rst data", ram_data, 128'd0);
    check("rst bank_full", 128'(bank_full), 128'd0);
    check("rst lines0", 128'(bank_lines_0), 128'd0);
    check("rst lines1", 128'(bank_lines_1), 128'd0);
    check("rst err", 128'(protocol_err), 128'd0);
    check("rst in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two back-to-back lines fill bank 0 (target 2).
    ready_miss = 0;
    for (int i = 1; i <= 16; i++) send(16'(i));
    in_valid = 1'b0;
    check("t1 close wr_en", 128'(ram_wr_en), 128'd1);
    check("t1 close addr", 128'(ram_addr), 128'd1);
    check("t1 bank_full", 128'(bank_full), 128'b01);
    check("t1 lines0", 128'(bank_lines_0), 128'd2);
    check("t1 in_ready", 128'(in_ready), 128'd1);
    check("t1 ready_miss", 128'(ready_miss), 128'd0);
    idle(2);
    expect_write("t1 line0", 4'h0, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    expect_write("t1 line1", 4'h1, 128'h0010_000f_000e_000d_000c_000b_000a_0009);

    // Bank 1 fills while bank 0 is unreleased: both full, stall.
    ready_miss = 0;
    for (int i = 17; i <= 32; i++) send(16'(i));
    in_valid = 1'b0;
    check("t2 bank_full", 128'(bank_full), 128'b11);
    check("t2 in_ready", 128'(in_ready), 128'd0);
    check("t2 lines1", 128'(bank_lines_1), 128'd2);
    check("t2 ready_miss", 128'(ready_miss), 128'd0);
    idle(2);
    expect_write("t2 line0", 4'h8, 128'h0018_0017_0016_0015_0014_0013_0012_0011);
    expect_write("t2 line1", 4'h9, 128'h0020_001f_001e_001d_001c_001b_001a_0019);
    bank_release = 2'b01;
    @(negedge clk);
    bank_release = 2'b00;
    check("t2 rel in_ready", 128'(in_ready), 128'd1);
    check("t2 rel bank_full", 128'(bank_full), 128'b10);
    check("t2 rel err", 128'(protocol_err), 128'd0);

    // Partial line of 3 then flush: zero-padded write at addr 0, bank closes with 1 line.
    ready_miss = 0;
    send(16'h000a);
    send(16'h000b);
    send(16'h000c);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t3 wr_en", 128'(ram_wr_en), 128'd1);
    check("t3 bank_full", 128'(bank_full), 128'b11);
    check("t3 lines0", 128'(bank_lines_0), 128'd1);
    check("t3 in_ready", 128'(in_ready), 128'd0);
    check("t3 ready_miss", 128'(ready_miss), 128'd0);
    idle(2);
    expect_write("t3 flush", 4'h0, 128'h0000_0000_0000_0000_0000_000c_000b_000a);
    bank_release = 2'b11;
    @(negedge clk);
    bank_release = 2'b00;
    check("t3 rel2 bank_full", 128'(bank_full), 128'b00);
    check("t3 rel2 in_ready", 128'(in_ready), 128'd1);
    check("t3 rel2 err", 128'(protocol_err), 128'd0);

    // Eighth element together with flush: full line, no padding, bank 1 closes.
    ready_miss = 0;
    for (int i = 16'h31; i <= 16'h37; i++) send(16'(i));
    flush = 1'b1;
    send(16'h0038);
    in_valid = 1'b0;
    flush = 1'b0;
    check("t4 bank_full", 128'(bank_full), 128'b10);
    check("t4 lines1", 128'(bank_lines_1), 128'd1);
    check("t4 in_ready", 128'(in_ready), 128'd1);
    check("t4 ready_miss", 128'(ready_miss), 128'd0);
    idle(2);
    expect_write("t4 line", 4'h8, 128'h0038_0037_0036_0035_0034_0033_0032_0031);

    // Flush on an empty FREE bank is a no-op.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(2);
    check("t5 noop writes", 128'(wq_addr.size()), 128'd0);
    check("t5 noop bank_full", 128'(bank_full), 128'b10);
    check("t5 noop err", 128'(protocol_err), 128'd0);

    // Legal release of bank 1, then release while FREE flags a sticky error.
    bank_release = 2'b10;
    @(negedge clk);
    bank_release = 2'b00;
    check("t5 rel bank_full", 128'(bank_full), 128'b00);
    check("t5 rel err", 128'(protocol_err), 128'd0);
    bank_release = 2'b10;
    @(negedge clk);
    bank_release = 2'b00;
    check("t5 bad rel err", 128'(protocol_err), 128'd1);
    check("t5 bad rel bank_full", 128'(bank_full), 128'b00);
    idle(3);
    check("t5 err held", 128'(protocol_err), 128'd1);
    check("t5 in_ready", 128'(in_ready), 128'd1);

    // Asynchronous reset after 5 elements discards the partial line.
    for (int i = 1; i <= 5; i++) send(16'(16'h50 + i));
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst wr_en", 128'(ram_wr_en), 128'd0);
    check("t6 rst addr", 128'(ram_addr), 128'd0);
    check("t6 rst data", ram_data, 128'd0);
    check("t6 rst lines0", 128'(bank_lines_0), 128'd0);
    check("t6 rst lines1", 128'(bank_lines_1), 128'd0);
    check("t6 rst err", 128'(protocol_err), 128'd0);
    check("t6 rst bank_full", 128'(bank_full), 128'd0);
    check("t6 rst in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    check("t6 no partial write", 128'(wq_addr.size()), 128'd0);
    for (int i = 16'h41; i <= 16'h48; i++) send(16'(i));
    idle(2);
    expect_write("t6 line", 4'h0, 128'h0048_0047_0046_0045_0044_0043_0042_0041);
    check("no extra writes", 128'(wq_addr.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
